// File: rtl/stream_sel_mux_if.sv
// Handshake bundle for stream_sel_mux: N producer channels, channel select, one consumer and status flags.
interface stream_sel_mux_if #(
    parameter int WIDTH       = 32,
    parameter int NUM_INPUTS  = 4,
    parameter int SELECT_BITS = 2
);
    logic [WIDTH-1:0]       in_data [NUM_INPUTS];
    logic [NUM_INPUTS-1:0]  in_valid;
    logic [NUM_INPUTS-1:0]  in_last;
    logic [NUM_INPUTS-1:0]  in_ready;
    logic [SELECT_BITS-1:0] select;
    logic [WIDTH-1:0]       out_data;
    logic                   out_valid;
    logic                   out_last;
    logic                   out_ready;
    logic                   locked;
    logic                   sel_err;

    modport master (
        output in_data, in_valid, in_last, select, out_ready,
        input  in_ready, out_data, out_valid, out_last, locked, sel_err
    );

    modport slave (
        input  in_data, in_valid, in_last, select, out_ready,
        output in_ready, out_data, out_valid, out_last, locked, sel_err
    );
endinterface

// File: rtl/stream_sel_mux.sv
// N-input stream selector with optional packet lock; 1-cycle accept->out_valid latency.
// A main+skid register pair absorbs out_ready back-pressure, so in_ready never depends on out_ready.
module stream_sel_mux #(
    parameter int WIDTH       = 32,
    parameter int NUM_INPUTS  = 4,
    parameter int SELECT_BITS = 2,
    parameter bit PACKET_LOCK = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    stream_sel_mux_if.slave bus
);
    if (NUM_INPUTS < 2 || (1 << SELECT_BITS) < NUM_INPUTS) begin : g_bad_param
        $error("stream_sel_mux: NUM_INPUTS must be >= 2 and fit in SELECT_BITS");
    end

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                 state, state_nxt;
    logic [SELECT_BITS-1:0] lock_sel;
    logic [SELECT_BITS-1:0] ch;
    logic                   ch_ok;
    logic                   sel_vld;
    logic                   sel_lst;
    logic [WIDTH-1:0]       sel_dat;
    logic                   accept;

    logic [WIDTH-1:0]       main_data, skid_data;
    logic                   main_valid, main_last;
    logic                   skid_valid, skid_last;

    assign ch    = (state == LOCKED) ? lock_sel : bus.select;
    assign ch_ok = 32'(ch) < NUM_INPUTS;

    // Decode by comparison so an out-of-range select never indexes the input array.
    always_comb begin
        sel_vld      = 1'b0;
        sel_lst      = 1'b0;
        sel_dat      = '0;
        bus.in_ready = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (ch == SELECT_BITS'(i)) begin
                sel_vld         = bus.in_valid[i];
                sel_lst         = bus.in_last[i];
                sel_dat         = bus.in_data[i];
                bus.in_ready[i] = !rst && !skid_valid;
            end
        end
    end

    assign accept = sel_vld && !skid_valid && !rst;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (PACKET_LOCK && accept && !sel_lst) state_nxt = LOCKED;
            LOCKED:  if (accept && sel_lst)                 state_nxt = IDLE;
            default:                                        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lock_sel <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == LOCKED) lock_sel <= ch;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_last  <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            skid_data  <= '0;
        end else if (main_valid && !bus.out_ready) begin
            // Main stalled: an accepted beat can only park in the (empty) skid.
            if (accept) begin
                skid_valid <= 1'b1;
                skid_last  <= sel_lst;
                skid_data  <= sel_dat;
            end
        end else if (skid_valid) begin
            main_valid <= 1'b1;
            main_last  <= skid_last;
            main_data  <= skid_data;
            skid_valid <= 1'b0;
        end else if (accept) begin
            main_valid <= 1'b1;
            main_last  <= sel_lst;
            main_data  <= sel_dat;
        end else begin
            main_valid <= 1'b0;
        end
    end

    assign bus.out_valid = main_valid;
    assign bus.out_last  = main_last;
    assign bus.out_data  = main_data;
    assign bus.locked    = (state == LOCKED);
    assign bus.sel_err   = (state == IDLE) && !ch_ok;
endmodule
